iob2axi_wr_split: RTL and testbench

Native-to-AXI4 write bridge that accepts one transfer of arbitrary length, up to 2^XFER_W−1 beats, and issues it as a sequence of INCR bursts. Each burst is capped at MAX_BURST beats and, when enabled, never crosses a 4 KB boundary. It sits between a native (IOb) master, such as a DMA engine or accelerator writeback, and the AXI4 interconnect. It reports completion through `ready` and the accumulated write-response status through `error`.

---
 rtl/iob2axi_wr_split_pkg.sv | 35 +++
 rtl/iob2axi_wr_split_if.sv | 53 +++++
 rtl/iob2axi_burst_calc.sv | 46 ++++
 rtl/iob2axi_wr_split.sv | 157 +++++++++++++++
 tb/tb_iob2axi_wr_split.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/iob2axi_wr_split_pkg.sv
// rtl/iob2axi_wr_split_pkg.sv - shared AXI widths, channel constants and FSM state type
//
// Purpose: common definitions imported by the write splitter, its AXI
// interface and the burst calculator.
package iob2axi_wr_split_pkg;

   localparam int AXI_LEN_W   = 8;
   localparam int AXI_ID_W    = 1;
   localparam int AXI_SIZE_W  = 3;
   localparam int AXI_BURST_W = 2;
   localparam int AXI_LOCK_W  = 1;
   localparam int AXI_CACHE_W = 4;
   localparam int AXI_PROT_W  = 3;
   localparam int AXI_QOS_W   = 4;
   localparam int AXI_RESP_W  = 2;

   localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR = 2'b01;
   // normal non-cacheable, modifiable
   localparam logic [AXI_CACHE_W-1:0] AXI_CACHE_CODE = 4'd2;
   // unprivileged, non-secure, data
   localparam logic [AXI_PROT_W-1:0]  AXI_PROT_CODE  = 3'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   // AXI awsize encoding for a bus of data_w bits
   function automatic logic [AXI_SIZE_W-1:0] axi_size(input int data_w);
      return AXI_SIZE_W'($clog2(data_w / 8));
   endfunction

endpackage

// File: rtl/iob2axi_wr_split_if.sv
// rtl/iob2axi_wr_split_if.sv - AXI4 write-channel bundle (AW, W, B) with master/slave modports
//
// Purpose: groups the AXI4 write address, write data and write response
// channels. The master modport drives aw*/w*/bready, the slave modport drives
// awready/wready/bvalid/bresp.
interface iob2axi_wr_split_if #(
   parameter int AXI_ADDR_W = 32,
   parameter int DATA_W     = 32
);
   import iob2axi_wr_split_pkg::*;

   logic [AXI_ID_W-1:0]    awid;
   logic [AXI_ADDR_W-1:0]  awaddr;
   logic [AXI_LEN_W-1:0]   awlen;
   logic [AXI_SIZE_W-1:0]  awsize;
   logic [AXI_BURST_W-1:0] awburst;
   logic [AXI_LOCK_W-1:0]  awlock;
   logic [AXI_CACHE_W-1:0] awcache;
   logic [AXI_PROT_W-1:0]  awprot;
   logic [AXI_QOS_W-1:0]   awqos;
   logic                   awvalid;
   logic                   awready;

   logic [AXI_ID_W-1:0]    wid;
   logic [DATA_W-1:0]      wdata;
   logic [DATA_W/8-1:0]    wstrb;
   logic                   wlast;
   logic                   wvalid;
   logic                   wready;

   logic [AXI_RESP_W-1:0]  bresp;
   logic                   bvalid;
   logic                   bready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
      input  awready,
      output wid, wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bresp, bvalid,
      output bready
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
      output awready,
      input  wid, wdata, wstrb, wlast, wvalid,
      output wready,
      output bresp, bvalid,
      input  bready
   );

endinterface

// File: rtl/iob2axi_burst_calc.sv
// rtl/iob2axi_burst_calc.sv - combinational size of the next INCR burst
//
// Purpose: burst = min(remain, MAX_BURST, beats left before the next 4 KB
// boundary). Reusable by a read-side splitter.
// Ports:
//   addr_lo_i  low 12 bits of the burst start byte address
//   remain_i   beats still to be issued in the transfer
//   burst_o    beats in the next burst ($clog2(MAX_BURST)+1 bits)
// Configuration: IOB2AXI_WR_4K_SPLIT_EN enables the 4 KB clip; without it the
// caller guarantees no crossing and only remain/MAX_BURST limit the burst.
module iob2axi_burst_calc #(
   parameter int DATA_W    = 32,
   parameter int XFER_W    = 16,
   parameter int MAX_BURST = 256
) (
   input  logic [11:0]               addr_lo_i,
   input  logic [XFER_W-1:0]         remain_i,
   output logic [$clog2(MAX_BURST):0] burst_o
);

   localparam int OFF_W = $clog2(DATA_W / 8);
   // wide enough for remain and for 4096 in bytes
   localparam int CW    = (XFER_W > 13) ? XFER_W : 13;

   logic [CW-1:0] to_4k;
   logic [CW-1:0] lim;

   always_comb begin
`ifdef IOB2AXI_WR_4K_SPLIT_EN
      to_4k = (CW'(4096) - CW'(addr_lo_i)) >> OFF_W;
`else
      to_4k = CW'(MAX_BURST);
`endif
      lim = CW'(MAX_BURST);
      if (to_4k < lim)
         lim = to_4k;
      if (CW'(remain_i) < lim)
         lim = CW'(remain_i);
      burst_o = ($clog2(MAX_BURST)+1)'(lim);
   end

`ifndef IOB2AXI_WR_4K_SPLIT_EN
   wire unused_addr_lo = ^addr_lo_i;
`endif

endmodule

// File: rtl/iob2axi_wr_split.sv
// rtl/iob2axi_wr_split.sv - native write stream to AXI4 INCR burst splitter
//
// Purpose: accepts one transfer (addr, length beats) and issues it as a
// sequence of single-outstanding AXI4 INCR bursts of at most MAX_BURST beats.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   run_i, addr_i,    transfer start pulse (sampled when ready_o=1),
//   length_i          start byte address, length in beats (0 = none)
//   ready_o, error_o  idle flag; OR of bresp[1] over the last transfer
//   s_valid_i, s_addr_i (ignored), s_wdata_i, s_wstrb_i, s_ready_o
//                     native write beat stream
//   m_axi             AXI4 write channels (master modport)
// Configuration: IOB2AXI_WR_4K_SPLIT_EN clips bursts at 4 KB boundaries.
module iob2axi_wr_split
   import iob2axi_wr_split_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int AXI_ADDR_W = ADDR_W,
   parameter int XFER_W     = 16,
   parameter int MAX_BURST  = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  run_i,
   input  logic [AXI_ADDR_W-1:0] addr_i,
   input  logic [XFER_W-1:0]     length_i,
   output logic                  ready_o,
   output logic                  error_o,
   input  logic                  s_valid_i,
   input  logic [ADDR_W-1:0]     s_addr_i,
   input  logic [DATA_W-1:0]     s_wdata_i,
   input  logic [DATA_W/8-1:0]   s_wstrb_i,
   output logic                  s_ready_o,
   iob2axi_wr_split_if.master    m_axi
);

   localparam int BURST_W = $clog2(MAX_BURST) + 1;
   localparam int STRB_W  = DATA_W / 8;
   localparam int OFF_W   = $clog2(STRB_W);
   localparam logic [AXI_ADDR_W-1:0] ALIGN_MASK = ~AXI_ADDR_W'(STRB_W - 1);

   state_t                state_q, state_d;
   logic [AXI_ADDR_W-1:0] addr_q, addr_d;
   logic [XFER_W-1:0]     remain_q, remain_d;
   logic [BURST_W-1:0]    burst_q, burst_d;
   logic [BURST_W-1:0]    beat_q, beat_d;
   logic                  error_q, error_d;
   logic [BURST_W-1:0]    burst_calc;
   logic                  last_beat;
   logic                  w_hs;

   // sized from the next-state address/remain so the burst is ready in the
   // first ADDR cycle
   iob2axi_burst_calc #(
      .DATA_W   (DATA_W),
      .XFER_W   (XFER_W),
      .MAX_BURST(MAX_BURST)
   ) u_burst_calc (
      .addr_lo_i(addr_d[11:0]),
      .remain_i (remain_d),
      .burst_o  (burst_calc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         remain_q <= '0;
         burst_q  <= '0;
         beat_q   <= '0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         remain_q <= remain_d;
         burst_q  <= burst_d;
         beat_q   <= beat_d;
         error_q  <= error_d;
      end
   end

   assign last_beat = (beat_q == burst_q - BURST_W'(1));
   assign w_hs      = s_valid_i & m_axi.wready;

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      remain_d = remain_q;
      beat_d   = beat_q;
      error_d  = error_q;
      case (state_q)
         ST_IDLE: begin
            if (run_i) begin
               error_d = 1'b0;
               if (length_i != '0) begin
                  addr_d   = addr_i & ALIGN_MASK;
                  remain_d = length_i;
                  state_d  = ST_ADDR;
               end
            end
         end
         ST_ADDR: begin
            if (m_axi.awready) begin
               beat_d  = '0;
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (w_hs) begin
               if (last_beat)
                  state_d = ST_RESP;
               else
                  beat_d = beat_q + BURST_W'(1);
            end
         end
         ST_RESP: begin
            if (m_axi.bvalid) begin
               error_d  = error_q | m_axi.bresp[1];
               addr_d   = addr_q + (AXI_ADDR_W'(burst_q) << OFF_W);
               remain_d = remain_q - XFER_W'(burst_q);
               state_d  = (remain_d != '0) ? ST_ADDR : ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // burst is captured only on entry to ADDR, keeping awlen stable under stall
   assign burst_d = ((state_d == ST_ADDR) && (state_q != ST_ADDR)) ? burst_calc : burst_q;

   assign ready_o   = (state_q == ST_IDLE);
   assign error_o   = error_q;
   assign s_ready_o = (state_q == ST_DATA) & m_axi.wready;

   assign m_axi.awid    = '0;
   assign m_axi.awaddr  = addr_q;
   assign m_axi.awlen   = AXI_LEN_W'(burst_q - BURST_W'(1));
   assign m_axi.awsize  = axi_size(DATA_W);
   assign m_axi.awburst = AXI_BURST_INCR;
   assign m_axi.awlock  = '0;
   assign m_axi.awcache = AXI_CACHE_CODE;
   assign m_axi.awprot  = AXI_PROT_CODE;
   assign m_axi.awqos   = '0;
   assign m_axi.awvalid = (state_q == ST_ADDR);

   assign m_axi.wid    = '0;
   assign m_axi.wdata  = s_wdata_i;
   assign m_axi.wstrb  = s_wstrb_i;
   assign m_axi.wvalid = (state_q == ST_DATA) & s_valid_i;
   assign m_axi.wlast  = (state_q == ST_DATA) & last_beat;

   assign m_axi.bready = (state_q == ST_RESP);

   wire unused_inputs = ^{s_addr_i, m_axi.bresp[0]};

endmodule

// File: tb/tb_iob2axi_wr_split.sv
// tb/tb_iob2axi_wr_split.sv - randomized bench with a burst-list reference model
module tb_iob2axi_wr_split;
   import iob2axi_wr_split_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic [31:0] addr;
   logic [15:0] length;
   logic        ready, error;
   logic        s_valid;
   logic [31:0] s_addr, s_wdata;
   logic [3:0]  s_wstrb;
   logic        s_ready;

   iob2axi_wr_split_if #(.AXI_ADDR_W(32), .DATA_W(32)) axi ();

   iob2axi_wr_split #(
      .ADDR_W(32), .DATA_W(32), .AXI_ADDR_W(32), .XFER_W(16), .MAX_BURST(256)
   ) dut (
      .clk(clk), .rst(rst),
      .run_i(run), .addr_i(addr), .length_i(length),
      .ready_o(ready), .error_o(error),
      .s_valid_i(s_valid), .s_addr_i(s_addr), .s_wdata_i(s_wdata), .s_wstrb_i(s_wstrb),
      .s_ready_o(s_ready),
      .m_axi(axi)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: the transfer as a list of bursts, plus handshake counters
   logic [31:0] exp_addr[$];
   int          exp_len[$];
   int          nb, aw_done, w_done, b_done, beat, xfer_beats, mon_k;
   bit          active, m_err;
   logic [31:0] aw_log_addr[$];
   int          aw_log_len[$];
   int          err_burst = -1;
   bit          stall = 1'b0;

   function automatic logic [31:0] data_of(input int k);
      return (32'(k) * 32'h9E37_79B9) ^ 32'h0F1E_2D3C;
   endfunction

   task automatic plan(input logic [31:0] a0, input int len);
      logic [31:0] a;
      int r, b;
`ifdef IOB2AXI_WR_4K_SPLIT_EN
      int lim4k;
`endif
      a = a0 & 32'hFFFF_FFFC;
      r = len;
      exp_addr.delete();
      exp_len.delete();
      while (r > 0) begin
         b = (r > 256) ? 256 : r;
`ifdef IOB2AXI_WR_4K_SPLIT_EN
         lim4k = (4096 - int'(a[11:0])) / 4;
         if (b > lim4k) b = lim4k;
`endif
         exp_addr.push_back(a);
         exp_len.push_back(b);
         a = a + 32'(b * 4);
         r -= b;
      end
   endtask

   // compare process: sampled at negedge, i.e. the values the next posedge sees
   always @(negedge clk) begin : mon
      bit exp_aw, in_data, in_resp, exp_last;
      if (rst) begin
         active = 1'b0; m_err = 1'b0; nb = 0;
         aw_done = 0; w_done = 0; b_done = 0; beat = 0;
      end else begin
         exp_aw   = active && (aw_done < nb) && (aw_done == b_done);
         in_data  = active && (aw_done > w_done);
         in_resp  = active && (w_done > b_done);
         exp_last = 1'b0;
         if (in_data) exp_last = (beat == exp_len[w_done] - 1);

         chk("ready", ready, !active);
         chk("awvalid", axi.awvalid, exp_aw);
         if (axi.awvalid && exp_aw) begin
            chk("awaddr", axi.awaddr, exp_addr[aw_done]);
            chk("awlen", axi.awlen, exp_len[aw_done] - 1);
            chk("aw_const", {axi.awid, axi.awsize, axi.awburst, axi.awlock, axi.awcache,
                             axi.awprot, axi.awqos}, {1'b0, 3'd2, 2'b01, 1'b0, 4'd2, 3'd2, 4'd0});
         end
         chk("wvalid", axi.wvalid, in_data && s_valid);
         chk("s_ready", s_ready, in_data && axi.wready);
         chk("wlast", axi.wlast, exp_last);
         chk("bready", axi.bready, in_resp);
         if (!active) chk("error", error, m_err);
         if (axi.wvalid) begin
            chk("wstrb", axi.wstrb, s_wstrb);
            chk("wid", axi.wid, 0);
         end

         if (axi.awvalid && axi.awready) begin
            aw_log_addr.push_back(axi.awaddr);
            aw_log_len.push_back(int'(axi.awlen));
            aw_done++;
         end
         if (axi.wvalid && axi.wready) begin
            chk("wdata", axi.wdata, data_of(mon_k));
            mon_k++;
            beat++;
            xfer_beats++;
            if (in_data && beat == exp_len[w_done]) begin
               w_done++;
               beat = 0;
            end
         end
         if (axi.bvalid && axi.bready) begin
            m_err = m_err | axi.bresp[1];
            b_done++;
            if (b_done >= nb) active = 1'b0;
         end
         if (run && ready) begin
            plan(addr, int'(length));
            nb = exp_addr.size();
            m_err = 1'b0;
            active = (nb > 0);
            aw_done = 0; w_done = 0; b_done = 0; beat = 0; xfer_beats = 0;
         end
      end
   end

   // AXI slave and native source, updated just after each rising edge
   initial begin
      axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
      s_valid = 1'b0; s_wdata = '0; s_wstrb = '0; s_addr = '0;
      forever begin
         @(posedge clk);
         #1;
         axi.awready = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
         axi.wready  = stall ? ($urandom_range(0, 1) == 0) : 1'b1;
         s_valid     = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
         s_wdata     = data_of(mon_k);
         s_wstrb     = 4'($urandom);
         s_addr      = $urandom;
         // B only after the burst's last W beat, held until accepted
         axi.bvalid  = (w_done > b_done) && (axi.bvalid || !stall || ($urandom_range(0, 2) == 0));
         axi.bresp   = {(b_done == err_burst), stall ? 1'($urandom) : 1'b0};
      end
   end

   task automatic do_xfer(input logic [31:0] a, input int len, output int cyc);
      aw_log_addr.delete();
      aw_log_len.delete();
      @(posedge clk);
      #2;
      run = 1'b1; addr = a; length = 16'(len);
      @(posedge clk);
      #2;
      run = 1'b0;
      cyc = 0;
      while (!ready && cyc < 20000) begin
         @(posedge clk);
         #2;
         cyc++;
      end
      chk("xfer_done", ready, 1);
      chk("xfer_beats", xfer_beats, len);
   endtask

   initial begin : main
      int cyc;
      int len;
      rst = 1'b1; run = 1'b0; addr = '0; length = '0;
      repeat (3) @(posedge clk);
      #2;
      chk("reset_outs", {ready, error, axi.awvalid, axi.wvalid, axi.wlast, axi.bready, s_ready},
          7'b1000000);
      @(posedge clk);
      #2;
      rst = 1'b0;

      // single short burst, always-ready slave: run to ready in 6 edges after sampling
      stall = 1'b0;
      do_xfer(32'h100, 4, cyc);
      chk("t1_cycles", cyc, 6);
      chk("t1_nburst", aw_log_addr.size(), 1);
      chk("t1_awaddr", aw_log_addr[0], 32'h100);
      chk("t1_awlen", aw_log_len[0], 3);
      chk("t1_error", error, 0);

      // MAX_BURST split
      do_xfer(32'h0, 600, cyc);
      chk("t2_nburst", aw_log_addr.size(), 3);
      chk("t2_b0", {aw_log_addr[0], 8'(aw_log_len[0])}, {32'h000, 8'd255});
      chk("t2_b1", {aw_log_addr[1], 8'(aw_log_len[1])}, {32'h400, 8'd255});
      chk("t2_b2", {aw_log_addr[2], 8'(aw_log_len[2])}, {32'h800, 8'd87});

      // 4 KB boundary
      do_xfer(32'hFF8, 8, cyc);
`ifdef IOB2AXI_WR_4K_SPLIT_EN
      chk("t3_nburst", aw_log_addr.size(), 2);
      chk("t3_b0", {aw_log_addr[0], 8'(aw_log_len[0])}, {32'hFF8, 8'd1});
      chk("t3_b1", {aw_log_addr[1], 8'(aw_log_len[1])}, {32'h1000, 8'd5});
`else
      chk("t3_nburst", aw_log_addr.size(), 1);
      chk("t3_b0", {aw_log_addr[0], 8'(aw_log_len[0])}, {32'hFF8, 8'd7});
`endif

      // unaligned start address is forced down to the beat boundary
      do_xfer(32'h103, 2, cyc);
      chk("t4_awaddr", aw_log_addr[0], 32'h100);

      // error on the middle burst, then a clean transfer clears it
      err_burst = 1;
      do_xfer(32'h0, 600, cyc);
      chk("t5_error_set", error, 1);
      err_burst = -1;
      do_xfer(32'h2000, 600, cyc);
      chk("t5_error_clr", error, 0);

      // randomized stalls and transfers
      stall = 1'b1;
      for (int i = 0; i < 8; i++) begin
         len = (i == 0) ? 37 : $urandom_range(1, 300);
         err_burst = (i % 3 == 2) ? $urandom_range(0, 1) : -1;
         do_xfer($urandom, len, cyc);
      end
      err_burst = -1;

      // reset in the middle of a data phase
      @(posedge clk);
      #2;
      run = 1'b1; addr = 32'h40; length = 16'd100;
      @(posedge clk);
      #2;
      run = 1'b0;
      cyc = 0;
      while (!axi.wvalid && cyc < 500) begin
         @(posedge clk);
         #2;
         cyc++;
      end
      chk("t6_in_data", axi.wvalid, 1);
      #1;
      rst = 1'b1;
      #1;
      chk("t6_rst_outs", {ready, error, axi.awvalid, axi.wvalid, axi.wlast, axi.bready, s_ready},
          7'b1000000);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b0;
      do_xfer(32'h500, 0, cyc);
      chk("t6_len0_ready", ready, 1);
      chk("t6_len0_cyc", cyc, 0);
      repeat (5) @(posedge clk);
      #2;
      chk("t6_no_aw", aw_log_addr.size(), 0);
      chk("t6_error", error, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #1_000_000;
      bad++;
      $display("FAIL watchdog: got timeout want completion");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
